// File: rtl/pacman_pkg.sv
// Shared types for the maze actors: heading encoding, ghost FSM states and maze size.
package pacman_pkg;

    localparam int unsigned MAZE_W = 28;
    localparam int unsigned MAZE_H = 31;

    // Encoding doubles as the bit index into the maze ROM exit vector.
    typedef enum logic [1:0] {
        UP    = 2'd0,
        LEFT  = 2'd1,
        DOWN  = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        CHOOSE = 2'd2
    } ghost_state_t;

    function automatic dir_t rev_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/ghost_dir_pick.sv
// Combinational heading chooser: picks the next direction from the tile's open exits,
// avoiding reversal unless the tile is a dead end.
module ghost_dir_pick
    import pacman_pkg::*;
(
    input  logic [3:0] open_dirs,
    input  dir_t       cur_dir,
    input  logic [2:0] random_num,
    output dir_t       next_dir,
    output logic       stay
);

    dir_t       rev;
    logic [3:0] cand;
    logic       multi;
    logic       found;
    logic [1:0] idx;

    always_comb begin
        rev      = rev_dir(cur_dir);
        cand     = open_dirs & ~(4'b0001 << rev);
        // More than one candidate exit: clearing the lowest set bit leaves something.
        multi    = |(cand & (cand - 4'd1));
        next_dir = cur_dir;
        stay     = 1'b0;
        found    = 1'b0;
        idx      = '0;

        if (cand == 4'b0000) begin
            if (open_dirs[rev]) begin
                next_dir = rev;
            end else begin
                stay = 1'b1;
            end
        end else if (multi && random_num[2] && cand[cur_dir]) begin
            next_dir = cur_dir;
        end else begin
            for (int unsigned k = 0; k < 4; k++) begin
                idx = random_num[1:0] + 2'(k);
                if (!found && cand[idx]) begin
                    next_dir = dir_t'(idx);
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ghost_move_ctrl.sv
// Tile-stepping ghost movement controller: one step per accepted move_tick, three-edge
// latency through a ROM wait cycle and a direction choice.
module ghost_move_ctrl
    import pacman_pkg::*;
#(
    parameter int unsigned GRID_W    = 28,
    parameter int unsigned GRID_H    = 31,
    parameter int unsigned X_W       = 5,
    parameter int unsigned Y_W       = 5,
    parameter int unsigned START_X   = 13,
    parameter int unsigned START_Y   = 11,
    parameter logic [1:0]  START_DIR = 2'd1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           enable,
    input  logic           move_tick,
    input  logic           respawn,
    input  logic [2:0]     random_num,
    input  logic [3:0]     open_dirs,
    output logic [X_W-1:0] ghost_x,
    output logic [Y_W-1:0] ghost_y,
    output logic [1:0]     ghost_dir,
    output logic           busy,
    output logic           step_done
);

    localparam logic [X_W-1:0] X_MAX  = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_MAX  = Y_W'(GRID_H - 1);
    localparam logic [X_W-1:0] X_INIT = X_W'(START_X);
    localparam logic [Y_W-1:0] Y_INIT = Y_W'(START_Y);
    localparam dir_t           D_INIT = dir_t'(START_DIR);

    ghost_state_t   state_q, state_d;
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    dir_t           dir_q, dir_d;
    logic           done_q, done_d;

    dir_t pick_dir;
    logic pick_stay;

    ghost_dir_pick u_pick (
        .open_dirs  (open_dirs),
        .cur_dir    (dir_q),
        .random_num (random_num),
        .next_dir   (pick_dir),
        .stay       (pick_stay)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (move_tick && enable) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
                state_d = CHOOSE;
            end
            CHOOSE: begin
                state_d = IDLE;
                done_d  = 1'b1;
                dir_d   = pick_dir;
                // Tunnel wrap on x; y saturates at the maze edge.
                if (!pick_stay) begin
                    case (pick_dir)
                        UP:      if (y_q != '0)    y_d = y_q - Y_W'(1);
                        DOWN:    if (y_q != Y_MAX) y_d = y_q + Y_W'(1);
                        LEFT:    x_d = (x_q == '0)    ? X_MAX : x_q - X_W'(1);
                        RIGHT:   x_d = (x_q == X_MAX) ? '0    : x_q + X_W'(1);
                        default: x_d = x_q;
                    endcase
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (respawn) begin
            state_d = IDLE;
            x_d     = X_INIT;
            y_d     = Y_INIT;
            dir_d   = D_INIT;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= X_INIT;
            y_q     <= Y_INIT;
            dir_q   <= D_INIT;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign ghost_x   = x_q;
    assign ghost_y   = y_q;
    assign ghost_dir = dir_q;
    assign busy      = (state_q != IDLE);
    assign step_done = done_q;

endmodule
